heat_stencil_jacobi: RTL and testbench
======================================

Name: heat_stencil_jacobi

Overview:
Parametrised 2-D 5-point-stencil heat-diffusion engine: the next generation of our fixed 5x5, 4-bit, in-place solver. Grid size, temperature width and alpha width are generic. The grid is double-buffered, so each sweep is a true Jacobi step: every cell reads only the previous sweep's values. Adds a run/iteration handshake, an abort, and selectable Dirichlet or Neumann (insulated) boundaries. A host command port writes and reads cells while the engine is idle.

Parameters:
GRID_W, 5, grid columns (>=3)
GRID_H, 5, grid rows (>=3)
TEMP_W, 4, bits per cell temperature (unsigned)
ALPHA_W, 3, bits of diffusion coefficient alpha
ALPHA_SHIFT, 3, right-shift applied to lap*alpha
ITER_W, 8, width of iteration count
ADDR_W, $clog2(GRID_W*GRID_H), cell address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  host command strobe
cmd_ready  out  1  high when idle; a command is accepted when cmd_valid & cmd_ready
cmd_op  in  2  00 write cell, 01 read cell, 10 set alpha, 11 set boundary (data[TEMP_W-1:0] = temp, data[TEMP_W] = mode)
cmd_addr  in  ADDR_W  row-major cell index (y*GRID_W+x)
cmd_data  in  TEMP_W+1  write / config data
rd_valid  out  1  one-cycle pulse with read data
rd_data  out  TEMP_W  cell value
start  in  1  begin run
iters  in  ITER_W  sweeps to run, sampled with start
abort  in  1  stop run immediately
busy  out  1  run in progress
done  out  1  one-cycle completion pulse
sweep_cnt  out  ITER_W  sweeps completed in current/last run

Behaviour:
- Reset: all cells of both banks = 0; bank pointer = 0; alpha = 2; boundary_temp = 0; mode = Dirichlet (0); FSM IDLE.
- Reset outputs: cmd_ready = 1, busy = 0, done = 0, rd_valid = 0, rd_data = 0, sweep_cnt = 0.
- Reset asserted mid-run: same as power-up reset; grid contents lost.
- FSM states: IDLE, RUN, FIN.
- IDLE -> RUN on start with iters != 0; sweep_cnt cleared, cell index = 0.
- start with iters == 0: stay IDLE, done pulses the next cycle, grid untouched.
- start while busy: ignored.
- RUN: one cell per cycle, row-major. Reads neighbours from bank cur, writes the result to bank nxt at the same index.
- End of each sweep (index == GRID_W*GRID_H-1): swap cur/nxt and increment sweep_cnt. When sweep_cnt reaches iters -> FIN.
- FIN (one cycle): done = 1, then IDLE.
- busy = 1 in RUN only, for exactly iters*GRID_W*GRID_H cycles, starting the cycle after start.
- abort in RUN: go to IDLE the next cycle with no swap. cur keeps the last completed sweep; done is not pulsed.
- Commands are accepted only when cmd_ready = 1 (IDLE); during RUN/FIN cmd_ready = 0.
- Write: updates bank cur at cmd_addr.
- Read: rd_valid and rd_data driven on the cycle after acceptance, from bank cur.
- cmd_addr >= GRID_W*GRID_H: writes are ignored; reads return 0 with rd_valid = 1.
- Stencil arithmetic:
  - sum = Tl+Tr+Tu+Td, width TEMP_W+2.
  - avg = sum >> 2.
  - lap = avg - Tc, signed, width TEMP_W+1.
  - delta = (lap * alpha) >>> ALPHA_SHIFT: arithmetic shift, floor rounding, full-width product.
  - Tnew = Tc + delta, clamped to [0, 2^TEMP_W-1].
- Dirichlet (mode 0): edge cells (x=0, x=GRID_W-1, y=0, y=GRID_H-1) are written boundary_temp each sweep. Interior cells use the stencil, reading edge values from cur.
- Neumann (mode 1): every cell uses the stencil; an out-of-grid neighbour is replaced by Tc.
- Config commands take effect on the next run; alpha/boundary cannot change mid-run.

Test Plan:
- 5x5, TEMP_W=4, alpha=7, Dirichlet boundary 0; cell 12 = 15, all others 0; start iters=1 -> cell 12 = 1, cells 7/11/13/17 = 2, all others 0; busy high 25 cycles; done pulses once; sweep_cnt = 1.
- All 0, Dirichlet boundary 12, alpha=7, iters=2 -> edge cells 12; cell 6 = 5, cell 7 = 2, cell 12 = 0 (confirms Jacobi, not in-place ordering).
- Uniform field 9, Neumann, alpha=7, iters=200 -> every cell reads 9; sweep_cnt = 200.
- ALPHA_W=4, alpha=15, Dirichlet 0, cell 12 = 15, iters=1 -> cell 12 clamps to 0; cells 7/11/13/17 = 5 (lap 3, 45>>>3).
- Control corners:
  - abort at cycle 30 of an iters=3 run -> grid equals the 1-sweep result, no done, sweep_cnt = 1.
  - start with iters=0 -> done next cycle, busy never high.
  - Read addr 25 -> rd_data = 0, rd_valid = 1.
  - Command during RUN -> cmd_ready = 0 and the command has no effect.
- Reset asserted mid-run -> all reads return 0, busy = 0, cmd_ready = 1 the cycle after reset releases.

Source files
------------

// File: rtl/heat_stencil_jacobi.sv
// Double-buffered 5-point-stencil heat-diffusion engine: one cell per cycle,
// Jacobi sweeps between two grid banks, host command port while idle.
module heat_stencil_jacobi #(
    parameter int GRID_W      = 5,
    parameter int GRID_H      = 5,
    parameter int TEMP_W      = 4,
    parameter int ALPHA_W     = 3,
    parameter int ALPHA_SHIFT = 3,
    parameter int ITER_W      = 8,
    parameter int ADDR_W      = $clog2(GRID_W*GRID_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [TEMP_W:0]   cmd_data,
    output logic              rd_valid,
    output logic [TEMP_W-1:0] rd_data,
    input  logic              start,
    input  logic [ITER_W-1:0] iters,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] sweep_cnt
);

    localparam int CELLS = GRID_W * GRID_H;
    localparam int XW    = $clog2(GRID_W);
    localparam int YW    = $clog2(GRID_H);
    localparam int PW    = TEMP_W + ALPHA_W + 2;

    localparam logic [ADDR_W-1:0]   GW_A     = ADDR_W'(GRID_W);
    localparam logic [ADDR_W-1:0]   LAST_A   = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W:0]     CELLS_A  = (ADDR_W + 1)'(CELLS);
    localparam logic [XW-1:0]       XMAX     = XW'(GRID_W - 1);
    localparam logic [YW-1:0]       YMAX     = YW'(GRID_H - 1);
    localparam logic signed [PW-1:0] TMAX_S  = PW'((1 << TEMP_W) - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    function automatic logic [TEMP_W-1:0] sat_temp(input logic signed [PW-1:0] v);
        if (v[PW-1])
            return '0;
        else if (v > TMAX_S)
            return TMAX_S[TEMP_W-1:0];
        else
            return v[TEMP_W-1:0];
    endfunction

    function automatic logic [TEMP_W-1:0] stencil_cell(
        input logic [TEMP_W-1:0]  tc,
        input logic [TEMP_W-1:0]  tl,
        input logic [TEMP_W-1:0]  tr,
        input logic [TEMP_W-1:0]  tu,
        input logic [TEMP_W-1:0]  td,
        input logic [ALPHA_W-1:0] a
    );
        logic [TEMP_W+1:0]      sum;
        logic [TEMP_W-1:0]      avg;
        logic signed [TEMP_W:0] lap;
        logic signed [PW-1:0]   lap_x;
        logic signed [PW-1:0]   alpha_x;
        logic signed [PW-1:0]   prod;
        logic signed [PW-1:0]   tsum;
        sum     = {2'b00, tl} + {2'b00, tr} + {2'b00, tu} + {2'b00, td};
        avg     = TEMP_W'(sum >> 2);
        lap     = $signed({1'b0, avg}) - $signed({1'b0, tc});
        lap_x   = $signed({{(PW-TEMP_W-1){lap[TEMP_W]}}, lap});
        alpha_x = $signed({{(PW-ALPHA_W){1'b0}}, a});
        prod    = lap_x * alpha_x;
        tsum    = $signed({{(PW-TEMP_W){1'b0}}, tc}) + (prod >>> ALPHA_SHIFT);
        return sat_temp(tsum);
    endfunction

    state_t              state, state_nxt;
    logic [TEMP_W-1:0]   grid [2][CELLS];
    logic                cur_ptr;
    logic                nxt_ptr;
    logic [ALPHA_W-1:0]  alpha;
    logic [TEMP_W-1:0]   btemp;
    logic                mode;
    logic [ADDR_W-1:0]   idx;
    logic [XW-1:0]       x_c;
    logic [YW-1:0]       y_c;
    logic [ITER_W-1:0]   iters_q;

    logic                cmd_acc;
    logic                addr_ok;
    logic [ADDR_W-1:0]   rd_idx;
    logic                at_left, at_right, at_top, at_bot;
    logic [ADDR_W-1:0]   il, ir, iu, id;
    logic [TEMP_W-1:0]   new_val;

    assign nxt_ptr = ~cur_ptr;
    assign cmd_acc = cmd_valid & cmd_ready;
    assign addr_ok = {1'b0, cmd_addr} < CELLS_A;
    assign rd_idx  = addr_ok ? cmd_addr : '0;

    // Off-grid neighbours map onto the centre cell, which is exactly the
    // insulated-edge substitution; Dirichlet edges are overridden below.
    assign at_left  = (x_c == '0);
    assign at_right = (x_c == XMAX);
    assign at_top   = (y_c == '0);
    assign at_bot   = (y_c == YMAX);
    assign il = at_left  ? idx : idx - 1'b1;
    assign ir = at_right ? idx : idx + 1'b1;
    assign iu = at_top   ? idx : idx - GW_A;
    assign id = at_bot   ? idx : idx + GW_A;

    always_comb begin
        new_val = stencil_cell(grid[cur_ptr][idx], grid[cur_ptr][il], grid[cur_ptr][ir],
                               grid[cur_ptr][iu], grid[cur_ptr][id], alpha);
        if (!mode && (at_left || at_right || at_top || at_bot))
            new_val = btemp;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (start)
                    state_nxt = (iters != '0) ? RUN : FIN;
            end
            RUN: begin
                busy = 1'b1;
                if (abort)
                    state_nxt = IDLE;
                else if (idx == LAST_A && (sweep_cnt + 1'b1) == iters_q)
                    state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < CELLS; i++)
                    grid[b][i] <= '0;
            cur_ptr   <= 1'b0;
            alpha     <= ALPHA_W'(2);
            btemp     <= '0;
            mode      <= 1'b0;
            idx       <= '0;
            x_c       <= '0;
            y_c       <= '0;
            sweep_cnt <= '0;
            iters_q   <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (cmd_acc) begin
                case (cmd_op)
                    2'b00: if (addr_ok) grid[cur_ptr][cmd_addr] <= cmd_data[TEMP_W-1:0];
                    2'b01: begin
                        rd_valid <= 1'b1;
                        rd_data  <= addr_ok ? grid[cur_ptr][rd_idx] : '0;
                    end
                    2'b10: alpha <= cmd_data[ALPHA_W-1:0];
                    default: begin
                        btemp <= cmd_data[TEMP_W-1:0];
                        mode  <= cmd_data[TEMP_W];
                    end
                endcase
            end
            if (state == IDLE && start && iters != '0) begin
                idx       <= '0;
                x_c       <= '0;
                y_c       <= '0;
                sweep_cnt <= '0;
                iters_q   <= iters;
            end
            // Aborting skips both the write and the bank swap, so cur keeps
            // the last fully completed sweep.
            if (state == RUN && !abort) begin
                grid[nxt_ptr][idx] <= new_val;
                if (idx == LAST_A) begin
                    cur_ptr   <= nxt_ptr;
                    sweep_cnt <= sweep_cnt + 1'b1;
                    idx       <= '0;
                    x_c       <= '0;
                    y_c       <= '0;
                end else begin
                    idx <= idx + 1'b1;
                    if (x_c == XMAX) begin
                        x_c <= '0;
                        y_c <= y_c + 1'b1;
                    end else begin
                        x_c <= x_c + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_heat_stencil_jacobi.sv
// Randomised bench for heat_stencil_jacobi against an array-based Jacobi
// reference model; alpha widened to 4 bits to reach the alpha=15 case.
module tb_heat_stencil_jacobi;

    localparam int GW  = 5;
    localparam int GH  = 5;
    localparam int TW  = 4;
    localparam int AW  = 4;
    localparam int SH  = 3;
    localparam int IW  = 8;
    localparam int N   = GW * GH;
    localparam int ADW = $clog2(N);

    logic           clk;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [ADW-1:0] cmd_addr;
    logic [TW:0]    cmd_data;
    logic           rd_valid;
    logic [TW-1:0]  rd_data;
    logic           start;
    logic [IW-1:0]  iters;
    logic           abort;
    logic           busy;
    logic           done;
    logic [IW-1:0]  sweep_cnt;

    heat_stencil_jacobi #(
        .GRID_W(GW), .GRID_H(GH), .TEMP_W(TW), .ALPHA_W(AW),
        .ALPHA_SHIFT(SH), .ITER_W(IW), .ADDR_W(ADW)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .start(start), .iters(iters), .abort(abort),
        .busy(busy), .done(done), .sweep_cnt(sweep_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int m[N];
    int malpha, mbt, mmode;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input int addr, input int data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = ADW'(addr);
        cmd_data  = (TW+1)'(data);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic write_cell(input int a, input int v);
        send(2'b00, a, v);
        if (a < N) m[a] = v;
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < N; i++) write_cell(i, v);
    endtask

    task automatic set_alpha(input int a);
        send(2'b10, 0, a);
        malpha = a;
    endtask

    task automatic set_bnd(input int md, input int t);
        send(2'b11, 0, md * (1 << TW) + t);
        mmode = md;
        mbt   = t;
    endtask

    task automatic read_cell(input int a, output int v, output int vl);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_addr  = ADW'(a);
        cmd_data  = '0;
        tick();
        v  = int'(rd_data);
        vl = int'(rd_valid);
        cmd_valid = 1'b0;
    endtask

    task automatic check_grid(input string tag);
        int v, vl;
        for (int i = 0; i < N; i++) begin
            read_cell(i, v, vl);
            chk($sformatf("%s[%0d]", tag, i), v, m[i]);
        end
    endtask

    task automatic spot(input string tag, input int a, input int exp);
        int v, vl;
        read_cell(a, v, vl);
        chk($sformatf("%s cell%0d", tag, a), v, exp);
    endtask

    // One Jacobi step over the whole grid using the textbook update rule.
    function automatic void model_sweep();
        int nx[N];
        int c, l, r, u, d, avg, lap, p, dl, t, i;
        int D;
        D = 1 << SH;
        for (int y = 0; y < GH; y++) begin
            for (int x = 0; x < GW; x++) begin
                i = y * GW + x;
                c = m[i];
                if (mmode == 0 && (x == 0 || x == GW-1 || y == 0 || y == GH-1)) begin
                    nx[i] = mbt;
                end else begin
                    l   = (x > 0)    ? m[i-1]  : c;
                    r   = (x < GW-1) ? m[i+1]  : c;
                    u   = (y > 0)    ? m[i-GW] : c;
                    d   = (y < GH-1) ? m[i+GW] : c;
                    avg = (l + r + u + d) / 4;
                    lap = avg - c;
                    p   = lap * malpha;
                    dl  = (p >= 0) ? p / D : -((-p + D - 1) / D);
                    t   = c + dl;
                    if (t < 0) t = 0;
                    if (t > (1 << TW) - 1) t = (1 << TW) - 1;
                    nx[i] = t;
                end
            end
        end
        m = nx;
    endfunction

    task automatic start_run(input int it);
        start = 1'b1;
        iters = IW'(it);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int bc, output int dc, output int ok);
        bc = 0;
        dc = 0;
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            if (busy) bc++;
            if (done) begin
                dc++;
                ok = 1;
                break;
            end
            tick();
        end
        if (ok == 1) begin
            tick();
            if (done) dc++;
        end
    endtask

    task automatic full_run(input string tag, input int it);
        int bc, dc, ok;
        start_run(it);
        wait_done(it * N + 20, bc, dc, ok);
        chk({tag, " finished"}, ok, 1);
        chk({tag, " busy cycles"}, bc, it * N);
        chk({tag, " done pulses"}, dc, 1);
        chk({tag, " sweep_cnt"}, int'(sweep_cnt), it);
        for (int k = 0; k < it; k++) model_sweep();
        check_grid(tag);
    endtask

    initial begin
        int v, vl, bc, dc, ok, dseen;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
        start = 1'b0; iters = '0; abort = 1'b0;
        for (int i = 0; i < N; i++) m[i] = 0;
        malpha = 2; mbt = 0; mmode = 0;
        tick(); tick(); tick();
        rst = 1'b0;

        chk("reset cmd_ready", int'(cmd_ready), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset rd_valid", int'(rd_valid), 0);
        chk("reset rd_data", int'(rd_data), 0);
        chk("reset sweep_cnt", int'(sweep_cnt), 0);
        check_grid("reset");

        // Single hot cell, Dirichlet 0
        set_alpha(7); set_bnd(0, 0); fill(0); write_cell(12, 15);
        full_run("hot", 1);
        spot("hot", 12, 1); spot("hot", 7, 2); spot("hot", 17, 2); spot("hot", 0, 0);

        // Jacobi ordering with a hot boundary
        fill(0); set_bnd(0, 12);
        full_run("bnd12", 2);
        spot("bnd12", 6, 5); spot("bnd12", 7, 2); spot("bnd12", 12, 0); spot("bnd12", 0, 12);

        // Insulated uniform field stays put
        fill(9); set_bnd(1, 0); set_alpha(7);
        full_run("neumann", 200);
        spot("neumann", 0, 9); spot("neumann", 12, 9);

        // Large alpha drives the centre below zero
        set_alpha(15); set_bnd(0, 0); fill(0); write_cell(12, 15);
        full_run("alpha15", 1);
        spot("alpha15", 12, 0); spot("alpha15", 7, 5);

        // Abort during the second sweep
        set_alpha(7); set_bnd(0, 0); fill(0); write_cell(12, 15);
        start_run(3);
        dseen = 0;
        for (int c = 0; c < 29; c++) begin
            if (done) dseen++;
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort cmd_ready", int'(cmd_ready), 1);
        chk("abort sweep_cnt", int'(sweep_cnt), 1);
        for (int c = 0; c < 4; c++) begin
            if (done) dseen++;
            tick();
        end
        chk("abort done pulses", dseen, 0);
        model_sweep();
        check_grid("abort");

        // Zero-iteration start
        start_run(0);
        chk("iters0 done", int'(done), 1);
        chk("iters0 busy", int'(busy), 0);
        tick();
        chk("iters0 done after", int'(done), 0);
        chk("iters0 busy after", int'(busy), 0);
        check_grid("iters0");

        // Out-of-range addresses
        read_cell(25, v, vl);
        chk("oor read data", v, 0);
        chk("oor read valid", vl, 1);
        write_cell(25, 7);
        write_cell(31, 5);
        read_cell(31, v, vl);
        chk("oor31 read data", v, 0);
        check_grid("oor");

        // Commands during a run are refused
        start_run(1);
        cmd_op = 2'b00; cmd_addr = ADW'(12); cmd_data = 5'd3;
        for (int c = 0; c < 5; c++) begin
            cmd_valid = 1'b1;
            chk("run cmd_ready", int'(cmd_ready), 0);
            tick();
        end
        cmd_valid = 1'b0;
        wait_done(N + 20, bc, dc, ok);
        chk("runcmd finished", ok, 1);
        model_sweep();
        check_grid("runcmd");

        // Randomised configurations
        for (int r = 0; r < 8; r++) begin
            set_alpha($urandom_range(0, 15));
            set_bnd($urandom_range(0, 1), $urandom_range(0, 15));
            for (int i = 0; i < N; i++) write_cell(i, $urandom_range(0, 15));
            full_run($sformatf("rand%0d", r), $urandom_range(1, 3));
        end

        // Reset in the middle of a run
        start_run(5);
        for (int c = 0; c < 10; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst busy", int'(busy), 0);
        chk("midrst cmd_ready", int'(cmd_ready), 1);
        chk("midrst sweep_cnt", int'(sweep_cnt), 0);
        for (int i = 0; i < N; i++) m[i] = 0;
        malpha = 2; mbt = 0; mmode = 0;
        check_grid("midrst");

        // Post-reset defaults (alpha 2, Dirichlet 0) drive a fresh run
        for (int i = 0; i < N; i++) write_cell(i, $urandom_range(0, 15));
        full_run("defaults", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
